// File: rtl/msdf_serializer_tx.sv
// ---------------------------------------------------------------------------
// msdf_serializer_tx
//   Parallel-to-digit-serial transmitter for the radix-2 MSDF mbus. A
//   two's-complement fraction is taken through a valid/ready handshake and
//   emitted MSD-first, one signed digit per cycle, on the mbus write channel.
//   The MSB (weight -1) becomes digit 0 as -1/0. Every other bit becomes a
//   +1/0 digit, so the value is carried exactly with no recoding.
//
//   Optional build macro: MSDF_TX_FLUSH_EN. When it is defined, FLUSH_DIGITS
//   zero digits are appended to each frame and wlast moves onto the final
//   zero digit.
//
// Ports
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_load_valid/_ready    load handshake (ready is combinational)
//   i_load_data            DIGIT_COUNT-bit two's-complement fraction
//   i_load_point           digit index that carries the point marker
//   o_mbus_wen/wvalid      frame enable / digit valid (registered)
//   o_mbus_wdata           encoded digit (ENCODING_MODE)
//   o_mbus_wpoint/wlast    point marker / final digit of frame
//   i_mbus_wstop           downstream stall
//   i_mbus_wclr            synchronous frame abort (beats stall and load)
// ---------------------------------------------------------------------------
module msdf_serializer_tx #(
  parameter string ENCODING_MODE = "signed-digit",
  parameter int    DIGIT_COUNT   = 16,
  parameter int    POINT_WIDTH   = 8,
  parameter int    FLUSH_DIGITS  = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [DIGIT_COUNT-1:0] i_load_data,
  input  logic [POINT_WIDTH-1:0] i_load_point,
  output logic                   o_mbus_wen,
  output logic [1:0]             o_mbus_wdata,
  output logic                   o_mbus_wpoint,
  output logic                   o_mbus_wvalid,
  output logic                   o_mbus_wlast,
  input  logic                   i_mbus_wstop,
  input  logic                   i_mbus_wclr
);

  localparam bit MODE_SD = (ENCODING_MODE == "signed-digit");
  localparam bit MODE_BS = (ENCODING_MODE == "borrow-save");
  // An unknown encoding keeps ready low, so the block never leaves IDLE and
  // every output stays at its reset value of 0.
  localparam bit MODE_OK = MODE_SD | MODE_BS;

`ifdef MSDF_TX_FLUSH_EN
  localparam int FLUSH_N = FLUSH_DIGITS;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FLUSH} state_e;
`else
  localparam int FLUSH_N = 0;
  typedef enum logic [0:0] {S_IDLE, S_SEND} state_e;
`endif

  localparam int LAST_IDX = DIGIT_COUNT + FLUSH_N - 1;
  localparam int CW       = $clog2(DIGIT_COUNT + FLUSH_DIGITS + 1);

  function automatic logic [1:0] enc(input logic pos, input logic neg);
    if (pos) return MODE_SD ? 2'b10 : 2'b01;
    if (neg) return MODE_SD ? 2'b01 : 2'b11;
    return 2'b00;
  endfunction

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;    // index of the digit currently on the bus
  logic [DIGIT_COUNT-1:0] sr_q;     // remaining data bits, next digit at MSB
  logic [POINT_WIDTH-1:0] point_q;
  logic                   wen_q, wpoint_q, wvalid_q, wlast_q;
  logic [1:0]             wdata_q;

  logic          accept;
  logic [CW-1:0] nxt_idx_d;
  logic          nxt_data_d, nxt_last_d, nxt_point_d;

  // Ready in IDLE, or on the final digit when the bus is moving. This lets the
  // next frame's digit 0 follow wlast directly.
  assign o_load_ready = MODE_OK & ~i_mbus_wclr &
                        ((state_q == S_IDLE) | (wlast_q & ~i_mbus_wstop));
  assign accept       = i_load_valid & o_load_ready;

  assign nxt_idx_d   = cnt_q + 1'b1;
  assign nxt_data_d  = 32'(nxt_idx_d) < DIGIT_COUNT;
  assign nxt_last_d  = 32'(nxt_idx_d) == LAST_IDX;
  // Flush digits never carry the point. This also keeps the marker off when
  // point >= DIGIT_COUNT.
  assign nxt_point_d = nxt_data_d & (32'(point_q) == 32'(nxt_idx_d));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      point_q  <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= 2'b00;
      wpoint_q <= 1'b0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
    end else if (i_mbus_wclr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= 2'b00;
      wpoint_q <= 1'b0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
    end else if (accept) begin
      // Digit 0 goes out now. The shift register keeps the rest, MSB-aligned.
      state_q  <= S_SEND;
      cnt_q    <= '0;
      sr_q     <= {i_load_data[DIGIT_COUNT-2:0], 1'b0};
      point_q  <= i_load_point;
      wen_q    <= 1'b1;
      wvalid_q <= 1'b1;
      wdata_q  <= enc(1'b0, i_load_data[DIGIT_COUNT-1]);
      wpoint_q <= (i_load_point == '0);
      wlast_q  <= 1'b0;
    end else if (state_q != S_IDLE && !i_mbus_wstop) begin
      if (wlast_q) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        sr_q     <= '0;
        wen_q    <= 1'b0;
        wdata_q  <= 2'b00;
        wpoint_q <= 1'b0;
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end else begin
        cnt_q    <= nxt_idx_d;
        sr_q     <= sr_q << 1;
        wdata_q  <= enc(nxt_data_d & sr_q[DIGIT_COUNT-1], 1'b0);
        wpoint_q <= nxt_point_d;
        wlast_q  <= nxt_last_d;
`ifdef MSDF_TX_FLUSH_EN
        state_q  <= nxt_data_d ? S_SEND : S_FLUSH;
`else
        state_q  <= S_SEND;
`endif
      end
    end
  end

  assign o_mbus_wen    = wen_q;
  assign o_mbus_wdata  = wdata_q;
  assign o_mbus_wpoint = wpoint_q;
  assign o_mbus_wvalid = wvalid_q;
  assign o_mbus_wlast  = wlast_q;

endmodule

// File: tb/tb_msdf_serializer_tx.sv
// ---------------------------------------------------------------------------
// tb_msdf_serializer_tx
//   Runs a signed-digit DUT and a borrow-save DUT side by side on the same
//   stimulus. A frame-level reference (a queue of expected digits, whose head
//   is the digit on the bus) predicts ready and the bus every cycle.
// ---------------------------------------------------------------------------
module tb_msdf_serializer_tx;
  localparam int DC = 8;
  localparam int PW = 8;
  localparam int FD = 3;
`ifdef MSDF_TX_FLUSH_EN
  localparam int L = DC + FD;
`else
  localparam int L = DC;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DC-1:0] ld_data = '0;
  logic [PW-1:0] ld_point = '0;
  logic          wstop = 1'b0, wclr = 1'b0;

  logic       rdy_sd, wen_sd, wpoint_sd, wvalid_sd, wlast_sd;
  logic [1:0] wdata_sd;
  logic       rdy_bs, wen_bs, wpoint_bs, wvalid_bs, wlast_bs;
  logic [1:0] wdata_bs;

  always #5 clk = ~clk;

  msdf_serializer_tx #(.ENCODING_MODE("signed-digit"), .DIGIT_COUNT(DC),
                       .POINT_WIDTH(PW), .FLUSH_DIGITS(FD)) u_dut_sd (
    .i_clk(clk), .i_rstn(rstn), .i_load_valid(ld_valid), .o_load_ready(rdy_sd),
    .i_load_data(ld_data), .i_load_point(ld_point), .o_mbus_wen(wen_sd),
    .o_mbus_wdata(wdata_sd), .o_mbus_wpoint(wpoint_sd), .o_mbus_wvalid(wvalid_sd),
    .o_mbus_wlast(wlast_sd), .i_mbus_wstop(wstop), .i_mbus_wclr(wclr));

  msdf_serializer_tx #(.ENCODING_MODE("borrow-save"), .DIGIT_COUNT(DC),
                       .POINT_WIDTH(PW), .FLUSH_DIGITS(FD)) u_dut_bs (
    .i_clk(clk), .i_rstn(rstn), .i_load_valid(ld_valid), .o_load_ready(rdy_bs),
    .i_load_data(ld_data), .i_load_point(ld_point), .o_mbus_wen(wen_bs),
    .o_mbus_wdata(wdata_bs), .o_mbus_wpoint(wpoint_bs), .o_mbus_wvalid(wvalid_bs),
    .o_mbus_wlast(wlast_bs), .i_mbus_wstop(wstop), .i_mbus_wclr(wclr));

  typedef struct {
    int v;
    bit pt;
    bit last;
  } dig_t;

  dig_t q[$];
  int   n_chk = 0, n_fail = 0;
  logic [15:0] seq_sd, seq_bs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input int v, input bit bs);
    if (v == 1)  return bs ? 2'b01 : 2'b10;
    if (v == -1) return bs ? 2'b11 : 2'b01;
    return 2'b00;
  endfunction

  // The value as signed digits: the MSB weighs -1 and each later bit +2^-k.
  // Frames end with zero flush digits when flushing is enabled.
  function automatic void build(input logic [DC-1:0] d, input logic [PW-1:0] p);
    q.delete();
    for (int k = 0; k < L; k++) begin
      dig_t r;
      if (k == 0)       r.v = d[DC-1] ? -1 : 0;
      else if (k < DC)  r.v = d[DC-1-k] ? 1 : 0;
      else              r.v = 0;
      r.pt   = (k < DC) && (int'(p) == k);
      r.last = (k == L - 1);
      q.push_back(r);
    end
  endfunction

  function automatic logic [5:0] exp_bus(input bit bs);
    if (q.size() == 0) return 6'd0;
    return {1'b1, enc(q[0].v, bs), q[0].pt, 1'b1, q[0].last};
  endfunction

  // One clock: drive at negedge, check ready, advance the model at posedge,
  // then check the bus.
  task automatic step(input bit v, input logic [DC-1:0] d, input logic [PW-1:0] p,
                      input bit st, input bit cl);
    bit er;
    @(negedge clk);
    ld_valid = v; ld_data = d; ld_point = p; wstop = st; wclr = cl;
    #1;
    er = !cl && (q.size() == 0 || (q.size() == 1 && !st));
    chk("ready_sd", 32'(rdy_sd), 32'(er));
    chk("ready_bs", 32'(rdy_bs), 32'(er));
    @(posedge clk);
    if (cl)                      q.delete();
    else if (v && er)            build(d, p);
    else if (q.size() != 0 && !st) q.delete(0);
    #1;
    chk("bus_sd", 32'({wen_sd, wdata_sd, wpoint_sd, wvalid_sd, wlast_sd}), 32'(exp_bus(1'b0)));
    chk("bus_bs", 32'({wen_bs, wdata_bs, wpoint_bs, wvalid_bs, wlast_bs}), 32'(exp_bus(1'b1)));
    seq_sd = {seq_sd[13:0], wdata_sd};
    seq_bs = {seq_bs[13:0], wdata_bs};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    ld_valid = 1'b0; wstop = 1'b0; wclr = 1'b0;
    #2 rstn = 1'b0;
    #1;
    q.delete();
    chk("rst_bus_sd", 32'({wen_sd, wdata_sd, wpoint_sd, wvalid_sd, wlast_sd}), 32'd0);
    chk("rst_bus_bs", 32'({wen_bs, wdata_bs, wpoint_bs, wvalid_bs, wlast_bs}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_bus_sd", 32'({wen_sd, wdata_sd, wpoint_sd, wvalid_sd, wlast_sd}), 32'd0);
    chk("reset_bus_bs", 32'({wen_bs, wdata_bs, wpoint_bs, wvalid_bs, wlast_bs}), 32'd0);
    chk("reset_ready", 32'(rdy_sd), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // -0.75, point 0, no stall: fixed digit sequences in both encodings.
    step(1'b1, 8'hA0, 8'd0, 1'b0, 1'b0);
    chk("first_digit_point", 32'(wpoint_sd), 32'd1);
    idle(DC - 1);
    chk("seq_sd_A0", 32'(seq_sd), 32'h4800);
    chk("seq_bs_A0", 32'(seq_bs), 32'hC400);
    idle(L - DC + 2);

    // Stall for 3 cycles while digit 2 is on the bus.
    step(1'b1, 8'hA0, 8'd2, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(L + 1);

    // Back-to-back frames with valid held high.
    step(1'b1, 8'h40, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < L; i++) step(1'b1, 8'hC0, 8'd1, 1'b0, 1'b0);
    chk("b2b_digit0", 32'({wen_sd, wdata_sd}), 32'b101);
    idle(L + 1);

    // Clear during digit 4, with a load offered on that edge. Then restart.
    step(1'b1, 8'h5A, 8'd4, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 8'h33, 8'd0, 1'b1, 1'b1);
    chk("clr_wen", 32'(wen_sd), 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 8'h81, 8'd7, 1'b0, 1'b0);
    idle(L + 1);

    // Point out of range: the marker never fires.
    step(1'b1, 8'hFF, 8'd9, 1'b0, 1'b0);
    idle(L + 1);

    // Async reset mid-frame (inside the flush tail when flushing is enabled).
    step(1'b1, 8'h7F, 8'd2, 1'b0, 1'b0);
    idle(L - 2);
    async_reset();
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, DC'($urandom), PW'($urandom_range(0, 11)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end
    idle(L + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
